// File: rtl/sha256_pkg.sv
// SHA-256 constants, round helper functions and the HMAC sequencer state type.
// Shared by the compression core and the HMAC top.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ROUND = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [7:0] IPAD = 8'h36;
    localparam logic [7:0] OPAD = 8'h5c;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [255:0] iv_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v[255-32*i -: 32] = IV[i];
        return v;
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 5'd2) ^ rotr(x, 5'd13) ^ rotr(x, 5'd22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 5'd6) ^ rotr(x, 5'd11) ^ rotr(x, 5'd25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 5'd7) ^ rotr(x, 5'd18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 5'd17) ^ rotr(x, 5'd19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] sha_ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] sha_maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_compress.sv
// One SHA-256 block compression: LOAD on i_start, 64 rounds, then an ADD cycle (o_done high).
// 66 cycles per block; no backpressure, i_start restarts the core unconditionally.
module sha256_compress
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_start,
    input  logic [511:0] i_block,
    input  logic [255:0] i_chain,
    output logic [255:0] o_result,
    output logic         o_done
);

    logic [31:0] r_w  [0:15];
    logic [31:0] r_v  [0:7];
    logic [31:0] r_cv [0:7];
    logic [6:0]  r_cnt;
    logic        r_act;

    logic [31:0] w_t1;
    logic [31:0] w_t2;
    logic [31:0] w_wnew;
    logic        w_round;

    assign w_round = r_act && !r_cnt[6];
    assign o_done  = r_act && r_cnt[6];

    // r_w[0] is W[t]; the word shifted in at the top is W[t+16]
    always_comb begin
        w_t1   = r_v[7] + big_sigma1(r_v[4]) + sha_ch(r_v[4], r_v[5], r_v[6])
               + K[r_cnt[5:0]] + r_w[0];
        w_t2   = big_sigma0(r_v[0]) + sha_maj(r_v[0], r_v[1], r_v[2]);
        w_wnew = small_sigma1(r_w[14]) + r_w[9] + small_sigma0(r_w[1]) + r_w[0];
    end

    always_comb begin
        o_result = '0;
        for (int i = 0; i < 8; i++) o_result[255-32*i -: 32] = r_cv[i] + r_v[i];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 16; i++) r_w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                r_v[i]  <= '0;
                r_cv[i] <= '0;
            end
            r_cnt <= '0;
            r_act <= 1'b0;
        end else if (i_start) begin
            for (int i = 0; i < 16; i++) r_w[i] <= i_block[511-32*i -: 32];
            for (int i = 0; i < 8; i++) begin
                r_v[i]  <= i_chain[255-32*i -: 32];
                r_cv[i] <= i_chain[255-32*i -: 32];
            end
            r_cnt <= '0;
            r_act <= 1'b1;
        end else if (w_round) begin
            for (int i = 0; i < 15; i++) r_w[i] <= r_w[i+1];
            r_w[15] <= w_wnew;
            r_v[0]  <= w_t1 + w_t2;
            r_v[1]  <= r_v[0];
            r_v[2]  <= r_v[1];
            r_v[3]  <= r_v[2];
            r_v[4]  <= r_v[3] + w_t1;
            r_v[5]  <= r_v[4];
            r_v[6]  <= r_v[5];
            r_v[7]  <= r_v[6];
            r_cnt   <= r_cnt + 7'd1;
        end else if (o_done) begin
            r_act <= 1'b0;
        end
    end

endmodule

// File: rtl/hmac_sha256_32_84.sv
// HMAC-SHA256 of a 32-byte key and 84-byte message over 5 sequential blocks.
// Result and one-cycle hash_done 330 cycles after the accepted enable; enable ignored while busy.
module hmac_sha256_32_84
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic [255:0] data,
    input  logic [671:0] msg,
    output logic [255:0] hash,
    output logic         hash_done
);

    state_t       r_state;
    logic [2:0]   r_blk;
    logic [5:0]   r_rnd;
    logic [255:0] r_key;
    logic [671:0] r_msg;
    logic [255:0] r_chain;
    logic [255:0] r_inner;

    logic [511:0] w_block;
    logic [255:0] w_result;
    logic         w_cmp_done;
    logic         w_start;

    assign w_start = (r_state == ST_LOAD);

    // Blocks 0-2 hash Ki || M, blocks 3-4 hash Ko || inner digest
    always_comb begin
        w_block = '0;
        case (r_blk)
            3'd0:    w_block = {r_key ^ {32{IPAD}}, {32{IPAD}}};
            3'd1:    w_block = r_msg[671:160];
            3'd2:    w_block = {r_msg[159:0], 8'h80, 280'd0, 64'd1184};
            3'd3:    w_block = {r_key ^ {32{OPAD}}, {32{OPAD}}};
            3'd4:    w_block = {r_inner, 8'h80, 184'd0, 64'd768};
            default: w_block = '0;
        endcase
    end

    sha256_compress u_compress (
        .clk      (clk),
        .n_rst    (n_rst),
        .i_start  (w_start),
        .i_block  (w_block),
        .i_chain  (r_chain),
        .o_result (w_result),
        .o_done   (w_cmp_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state   <= ST_IDLE;
            r_blk     <= '0;
            r_rnd     <= '0;
            r_key     <= '0;
            r_msg     <= '0;
            r_chain   <= '0;
            r_inner   <= '0;
            hash      <= '0;
            hash_done <= 1'b0;
        end else begin
            hash_done <= 1'b0;
            case (r_state)
                // DONE accepts a start so results can run back to back
                ST_IDLE, ST_DONE: begin
                    if (enable) begin
                        r_key   <= data;
                        r_msg   <= msg;
                        r_blk   <= '0;
                        r_chain <= iv_vec();
                        r_state <= ST_LOAD;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    r_rnd   <= '0;
                    r_state <= ST_ROUND;
                end
                ST_ROUND: begin
                    r_rnd <= r_rnd + 6'd1;
                    if (r_rnd == 6'd63) r_state <= ST_ADD;
                end
                ST_ADD: begin
                    if (w_cmp_done) begin
                        if (r_blk == 3'd4) begin
                            hash      <= w_result;
                            hash_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            if (r_blk == 3'd2) begin
                                r_inner <= w_result;
                                r_chain <= iv_vec();
                            end else begin
                                r_chain <= w_result;
                            end
                            r_blk   <= r_blk + 3'd1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hmac_sha256_32_84.sv
// Directed bench for hmac_sha256_32_84 against an independent byte-level HMAC-SHA256 model.
module tb_hmac_sha256_32_84;

    logic         clk;
    logic         n_rst;
    logic         enable;
    logic [255:0] data;
    logic [671:0] msg;
    logic [255:0] hash;
    logic         hash_done;

    int n_tests = 0;
    int n_fail  = 0;

    hmac_sha256_32_84 dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .enable    (enable),
        .data      (data),
        .msg       (msg),
        .hash      (hash),
        .hash_done (hash_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] TK [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [31:0] TIV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    typedef struct {
        logic [255:0] key;
        logic [671:0] msg;
        logic [255:0] exp;
    } vec_t;

    vec_t vt [0:3];

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Generic SHA-256 over up to 183 bytes with standard padding
    function automatic logic [255:0] sha_model(input logic [7:0] m [0:191], input int len);
        logic [7:0]  p  [0:191];
        logic [31:0] w  [0:63];
        logic [31:0] hv [0:7];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [63:0] bits;
        int nb;
        nb = (len + 9 + 63) / 64;
        for (int i = 0; i < 192; i++) p[i] = (i < len) ? m[i] : 8'h00;
        p[len] = 8'h80;
        bits = 64'(len * 8);
        for (int i = 0; i < 8; i++) p[nb*64-1-i] = bits[8*i +: 8];
        for (int i = 0; i < 8; i++) hv[i] = TIV[i];
        for (int bk = 0; bk < nb; bk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[bk*64+4*t], p[bk*64+4*t+1], p[bk*64+4*t+2], p[bk*64+4*t+3]};
            for (int t = 16; t < 64; t++)
                w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                     + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
            a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
            e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
            for (int t = 0; t < 64; t++) begin
                t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + TK[t] + w[t];
                t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                h = g; g = f; f = e; e = d + t1;
                d = c; c = b; b = a; a = t1 + t2;
            end
            hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
            hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
        end
        return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    endfunction

    function automatic logic [255:0] hmac_model(input logic [255:0] key, input logic [671:0] m);
        logic [7:0]   ib [0:191];
        logic [7:0]   ob [0:191];
        logic [7:0]   kb;
        logic [255:0] inner;
        for (int i = 0; i < 192; i++) begin
            ib[i] = 8'h00;
            ob[i] = 8'h00;
        end
        for (int i = 0; i < 64; i++) begin
            kb    = (i < 32) ? key[255-8*i -: 8] : 8'h00;
            ib[i] = kb ^ 8'h36;
            ob[i] = kb ^ 8'h5c;
        end
        for (int i = 0; i < 84; i++) ib[64+i] = m[671-8*i -: 8];
        inner = sha_model(ib, 148);
        for (int i = 0; i < 32; i++) ob[64+i] = inner[255-8*i -: 8];
        return sha_model(ob, 96);
    endfunction

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input int vi);
        data   = vt[vi].key;
        msg    = vt[vi].msg;
        enable = 1'b1;
    endtask

    // Call at a negedge with enable already driven; the next posedge is E0.
    task automatic run_op(input int vi, input int hold, input bit chg, input int nxt,
                          input bit chk_hold, input logic [255:0] held);
        int           pulses;
        int           at;
        logic [255:0] got;
        bit           herr;
        pulses = 0;
        at     = -1;
        got    = '0;
        herr   = 1'b0;
        @(posedge clk);
        for (int k = 0; k <= 340; k++) begin
            @(negedge clk);
            if (k >= hold - 1) enable = 1'b0;
            if (chg && k == 0) begin
                data = ~data;
                msg  = ~msg;
            end
            if (hash_done) begin
                pulses++;
                if (at < 0) at = k;
                got = hash;
            end
            if (chk_hold && k < 330 && hash !== held) herr = 1'b1;
            if (k == 330 && nxt >= 0) begin
                drive(nxt);
                break;
            end
        end
        check($sformatf("v%0d_done_count", vi), 256'(pulses), 256'd1);
        check($sformatf("v%0d_done_cycle", vi), 256'(at), 256'd330);
        check($sformatf("v%0d_hash", vi), got, vt[vi].exp);
        if (chk_hold) check("b2b_hash_held", 256'(herr), 256'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] sb [0:191];
        int         pulses;

        n_rst  = 1'b0;
        enable = 1'b0;
        data   = '0;
        msg    = '0;

        for (int i = 0; i < 32; i++) begin
            vt[0].key[255-8*i -: 8] = 8'h01;
            vt[1].key[255-8*i -: 8] = 8'(i);
            vt[2].key[255-8*i -: 8] = 8'hff;
            vt[3].key[255-8*i -: 8] = 8'(8'h80 + 8'(3*i));
        end
        for (int i = 0; i < 84; i++) begin
            vt[0].msg[671-8*i -: 8] = 8'h01;
            vt[1].msg[671-8*i -: 8] = 8'(i);
            vt[2].msg[671-8*i -: 8] = 8'haa;
            vt[3].msg[671-8*i -: 8] = 8'(8'h53 - 8'(i));
        end
        for (int v = 0; v < 4; v++) vt[v].exp = hmac_model(vt[v].key, vt[v].msg);

        // Model sanity against published SHA-256 digests
        for (int i = 0; i < 192; i++) sb[i] = 8'h00;
        sb[0] = 8'h61; sb[1] = 8'h62; sb[2] = 8'h63;
        check("model_sha_abc", sha_model(sb, 3),
              256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        check("model_sha_empty", sha_model(sb, 0),
              256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);

        #7;
        check("rst_hash_during", hash, 256'd0);
        check("rst_done_during", 256'(hash_done), 256'd0);
        #13;
        n_rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (hash_done) pulses++;
        end
        check("rst_hash_after", hash, 256'd0);
        check("rst_done_after", 256'(pulses), 256'd0);

        for (int v = 0; v < 4; v++) begin
            drive(v);
            run_op(v, 1, 1'b0, -1, 1'b0, '0);
        end

        // enable held for 50 cycles: only the first edge starts an operation
        drive(1);
        run_op(1, 50, 1'b0, -1, 1'b0, '0);

        // inputs change right after the start edge
        drive(0);
        run_op(0, 1, 1'b1, -1, 1'b0, '0);

        // back-to-back: second start issued in the hash_done cycle
        drive(1);
        run_op(1, 1, 1'b0, 2, 1'b0, '0);
        run_op(2, 1, 1'b0, -1, 1'b1, vt[1].exp);

        // reset in the middle of an operation
        drive(3);
        @(posedge clk);
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            enable = 1'b0;
        end
        n_rst = 1'b0;
        #1;
        check("abort_hash_zero", hash, 256'd0);
        check("abort_done_low", 256'(hash_done), 256'd0);
        @(negedge clk);
        n_rst = 1'b1;
        pulses = 0;
        for (int k = 0; k < 340; k++) begin
            @(negedge clk);
            if (hash_done) pulses++;
        end
        check("abort_no_done", 256'(pulses), 256'd0);
        check("abort_hash_stays_zero", hash, 256'd0);

        drive(3);
        run_op(3, 1, 1'b0, -1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
